// File: rtl/block_memory_arbiter.sv
// block_memory_arbiter: round-robin arbiter with bounded lock sharing block_memory's user port between two clients
//   clk, rst            : clock (shared with block_memory.user_clk), async active-high reset
//   reqN/weN/lockN      : client N request, write select, keep-ownership request
//   addrN/dinN          : client N address and write data
//   gntN                : combinational grant, access accepted on reqN && gntN at a rising edge
//   doutN/rvalidN       : read data (mirrors user_dout) and its one-cycle valid pulse for client N
//   user_addr/din/we    : registered BRAM request, user_dout : BRAM read data
module block_memory_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH = 33,
  parameter int READ_LATENCY = 2,
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]      din0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [WIDTH-1:0]      dout0,
  output logic [WIDTH-1:0]      dout1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [ADDR_WIDTH-1:0] user_addr,
  output logic [WIDTH-1:0]      user_din,
  output logic                  user_we,
  input  logic [WIDTH-1:0]      user_dout
);
  logic                  last, held, sel, acc, s_we, s_lock, other;
  logic [7:0]            lock_cnt;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [WIDTH-1:0]      s_din;
  // Head stage lines up with the user_addr register, the remaining READ_LATENCY stages cover the BRAM.
  logic [READ_LATENCY:0] vpipe, idpipe;
  always_comb begin
    sel = (req0 && req1) ? ((held && lock_cnt < 8'(MAX_LOCK)) ? last : !last) : req1;
    acc = !rst && (req0 || req1);
    s_we = sel ? we1 : we0;
    s_lock = sel ? lock1 : lock0;
    s_addr = sel ? addr1 : addr0;
    s_din = sel ? din1 : din0;
    other = sel ? req0 : req1;
  end
  assign gnt0 = acc && !sel;
  assign gnt1 = acc && sel;
  assign dout0 = user_dout;
  assign dout1 = user_dout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_addr <= '0;
      user_din <= '0;
      user_we <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      last <= 1'b1;
      held <= 1'b0;
      lock_cnt <= 8'd0;
      vpipe <= '0;
      idpipe <= '0;
    end else begin
      user_we <= acc && s_we;
      vpipe <= {vpipe[READ_LATENCY-1:0], acc && !s_we};
      idpipe <= {idpipe[READ_LATENCY-1:0], sel};
      rvalid0 <= vpipe[READ_LATENCY] && !idpipe[READ_LATENCY];
      rvalid1 <= vpipe[READ_LATENCY] && idpipe[READ_LATENCY];
      if (acc) begin
        user_addr <= s_addr;
        user_din <= s_din;
        last <= sel;
        held <= s_lock;
        // The accept itself counts, so a locked owner gets exactly MAX_LOCK accepts against a waiter.
        lock_cnt <= (other && s_lock) ? ((sel == last) ? lock_cnt + 8'd1 : 8'd1) : 8'd0;
      end
    end
  end
endmodule
